// File: rtl/pe_row_feeder_pkg.sv
// rtl/pe_row_feeder_pkg.sv - shared widths, row geometry and feeder FSM states
package definition;

   localparam int width     = 16;
   localparam int ROW_LEN   = 4;
   localparam int ROW_DRAIN = 4;

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      DRAIN,
      DONE
   } feeder_state_t;

endpackage

// File: rtl/pe_row_feeder_if.sv
// rtl/pe_row_feeder_if.sv - tile-controller side bus of the PE row feeder
interface pe_row_feeder_if #(
   parameter int WIDTH = definition::width,
   parameter int LEN   = definition::ROW_LEN
) ();

   localparam int AW = (LEN > 1) ? $clog2(LEN) : 1;

   logic                 wr_en;
   logic                 wr_sel;
   logic [AW-1:0]        wr_addr;
   logic [WIDTH-1:0]     wr_data;
   logic                 start;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   result;
   logic                 result_valid;

   modport master (
      output wr_en, wr_sel, wr_addr, wr_data, start,
      input  busy, done, result, result_valid
   );

   modport slave (
      input  wr_en, wr_sel, wr_addr, wr_data, start,
      output busy, done, result, result_valid
   );

endinterface

// File: rtl/pe_row_opbuf.sv
// rtl/pe_row_opbuf.sv - LEN x WIDTH operand register buffer with indexed read
module pe_row_opbuf
   import definition::*;
#(
   parameter int WIDTH = width,
   parameter int LEN   = ROW_LEN
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   we,
   input  logic [((LEN > 1) ? $clog2(LEN) : 1)-1:0] wr_addr,
   input  logic [WIDTH-1:0]                       wr_data,
   input  logic [((LEN > 1) ? $clog2(LEN) : 1)-1:0] rd_addr,
   output logic [WIDTH-1:0]                       rd_data
);

   logic [LEN-1:0][WIDTH-1:0] mem_q;
   logic [LEN-1:0][WIDTH-1:0] mem_d;

   // next buffer contents: one element replaced when the write is enabled
   always_comb begin
      mem_d = mem_q;
      if (we) begin
         mem_d[wr_addr] = wr_data;
      end
   end

   // buffer storage, cleared on reset
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q <= '0;
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/pe_row_feeder.sv
// rtl/pe_row_feeder.sv - operand sequencer and psum collector for a systolic PE row
module pe_row_feeder #(
   parameter int WIDTH = definition::width,
   parameter int LEN   = definition::ROW_LEN,
   parameter int DRAIN = definition::ROW_DRAIN
) (
   input  logic                 clk,
   input  logic                 rst,
   pe_row_feeder_if.slave       ctl,
   output logic [WIDTH-1:0]     o_r,
   output logic [WIDTH-1:0]     o_f,
   output logic                 o_en,
   input  logic [2*WIDTH-1:0]   i_psum
);

   localparam int AW      = (LEN > 1) ? $clog2(LEN) : 1;
   localparam int CNT_MAX = (LEN > DRAIN) ? LEN : DRAIN;
   localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CW-1:0] LEN_LAST   = CW'(LEN - 1);
   localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN - 1);
   localparam logic [AW:0]   LEN_LIM    = (AW + 1)'(LEN);

   definition::feeder_state_t state_q, state_d;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic [2*WIDTH-1:0]        result_q, result_d;
   logic                      result_valid_q, result_valid_d;

   logic                      wr_ok;
   logic [WIDTH-1:0]          ifmap_rd;
   logic [WIDTH-1:0]          filter_rd;

   // writes only land while idle and only for in-range element indices
   always_comb begin
      wr_ok = ctl.wr_en && (state_q == definition::IDLE) &&
              ({1'b0, ctl.wr_addr} < LEN_LIM);
   end

   pe_row_opbuf #(
      .WIDTH (WIDTH),
      .LEN   (LEN)
   ) u_ifmap (
      .clk     (clk),
      .rst     (rst),
      .we      (wr_ok && !ctl.wr_sel),
      .wr_addr (ctl.wr_addr),
      .wr_data (ctl.wr_data),
      .rd_addr (cnt_q[AW-1:0]),
      .rd_data (ifmap_rd)
   );

   pe_row_opbuf #(
      .WIDTH (WIDTH),
      .LEN   (LEN)
   ) u_filter (
      .clk     (clk),
      .rst     (rst),
      .we      (wr_ok && ctl.wr_sel),
      .wr_addr (ctl.wr_addr),
      .wr_data (ctl.wr_data),
      .rd_addr (cnt_q[AW-1:0]),
      .rd_data (filter_rd)
   );

   // pass sequencing: stream LEN operands, pad DRAIN zero cycles, capture psum
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      result_d       = result_q;
      result_valid_d = result_valid_q;
      case (state_q)
         definition::IDLE: begin
            if (ctl.start) begin
               state_d        = definition::STREAM;
               cnt_d          = '0;
               result_valid_d = 1'b0;
            end
         end
         definition::STREAM: begin
            if (cnt_q == LEN_LAST) begin
               state_d = definition::DRAIN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         definition::DRAIN: begin
            if (cnt_q == DRAIN_LAST) begin
               state_d        = definition::DONE;
               cnt_d          = '0;
               result_d       = i_psum;
               result_valid_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         definition::DONE: begin
            state_d = definition::IDLE;
         end
         default: begin
            state_d = definition::IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // state, counter and held result registers; reset aborts any pass
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= definition::IDLE;
         cnt_q          <= '0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
      end
   end

   // row drive and status decoded purely from registered state
   always_comb begin
      o_en = (state_q == definition::STREAM) || (state_q == definition::DRAIN);
      o_r  = (state_q == definition::STREAM) ? ifmap_rd  : '0;
      o_f  = (state_q == definition::STREAM) ? filter_rd : '0;
   end

   assign ctl.busy         = (state_q != definition::IDLE);
   assign ctl.done         = (state_q == definition::DONE);
   assign ctl.result       = result_q;
   assign ctl.result_valid = result_valid_q;

endmodule

// File: tb/tb_pe_row_feeder.sv
// tb/tb_pe_row_feeder.sv - scoreboard bench for pe_row_feeder
module tb_pe_row_feeder;

   localparam int W   = 16;
   localparam int LEN = 4;
   localparam int DRN = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [W-1:0]      o_r;
   logic [W-1:0]      o_f;
   logic              o_en;
   logic [2*W-1:0]    i_psum;

   always #5 clk = ~clk;

   pe_row_feeder_if #(.WIDTH(W), .LEN(LEN)) bus ();

   pe_row_feeder #(.WIDTH(W), .LEN(LEN), .DRAIN(DRN)) dut (
      .clk    (clk),
      .rst    (rst),
      .ctl    (bus),
      .o_r    (o_r),
      .o_f    (o_f),
      .o_en   (o_en),
      .i_psum (i_psum)
   );

   typedef struct {
      logic [W-1:0] r;
      logic [W-1:0] f;
      int           cyc;
   } op_t;

   typedef struct {
      logic [2*W-1:0] v;
      int             cyc;
   } res_t;

   op_t          exp_op[$];
   res_t         exp_res[$];
   int           cycno = 0;
   logic [31:0]  pcyc = 0;
   bit           start_expect = 1'b0;
   int           last_start = 0;
   logic [W-1:0] mdl_r[LEN];
   logic [W-1:0] mdl_f[LEN];
   logic [W-1:0] fv[LEN];
   int           n_checks = 0;
   int           n_pass = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end else begin
         n_pass++;
      end
   endtask

   // cycle counter; row psum equals the cycle number within the current pass
   always @(posedge clk) begin
      cycno <= cycno + 1;
      pcyc  <= start_expect ? 32'd1 : pcyc + 32'd1;
   end
   assign i_psum = pcyc[2*W-1:0];

   // scoreboard monitor, sampled just after each active edge
   always @(posedge clk) begin : mon
      op_t  e;
      res_t rr;
      #1;
      if (o_en === 1'b1) begin
         if (exp_op.size() == 0) begin
            check("unexpected_en", o_en, 0);
         end else begin
            e = exp_op.pop_front();
            check("o_r", o_r, e.r);
            check("o_f", o_f, e.f);
            check("op_cycle", cycno, e.cyc);
         end
      end
      if (bus.done === 1'b1) begin
         if (exp_res.size() == 0) begin
            check("unexpected_done", bus.done, 0);
         end else begin
            rr = exp_res.pop_front();
            check("result", bus.result, rr.v);
            check("rv_at_done", bus.result_valid, 1);
            check("done_cycle", cycno, rr.cyc);
            check("ops_drained", exp_op.size(), 0);
         end
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic set_write(input bit sel, input int addr, input logic [W-1:0] data, input bit commit);
      bus.wr_en   = 1'b1;
      bus.wr_sel  = sel;
      bus.wr_addr = addr[1:0];
      bus.wr_data = data;
      if (commit) begin
         if (sel) mdl_f[addr] = data;
         else     mdl_r[addr] = data;
      end
   endtask

   task automatic do_write(input bit sel, input int addr, input logic [W-1:0] data);
      set_write(sel, addr, data, 1'b1);
      tick();
      bus.wr_en = 1'b0;
   endtask

   task automatic start_pass();
      bus.start    = 1'b1;
      start_expect = 1'b1;
      last_start   = cycno;
      for (int k = 0; k < LEN; k++) exp_op.push_back('{mdl_r[k], mdl_f[k], cycno + 1 + k});
      for (int j = 0; j < DRN; j++) exp_op.push_back('{'0, '0, cycno + 1 + LEN + j});
      exp_res.push_back('{32'(LEN + DRN), cycno + 1 + LEN + DRN});
      tick();
      bus.start    = 1'b0;
      start_expect = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (bus.done !== 1'b1 && n < 30) begin
         tick();
         n++;
      end
      if (bus.done !== 1'b1) check("done_timeout", bus.done, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int ca;
      int cb;
      rst         = 1'b1;
      bus.wr_en   = 1'b0;
      bus.wr_sel  = 1'b0;
      bus.wr_addr = '0;
      bus.wr_data = '0;
      bus.start   = 1'b0;
      fv[0] = 1; fv[1] = 2; fv[2] = 3; fv[3] = 0;
      for (int k = 0; k < LEN; k++) begin
         mdl_r[k] = '0;
         mdl_f[k] = '0;
      end
      repeat (3) tick();
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_o_en", o_en, 0);
      check("rst_o_r", o_r, 0);
      check("rst_o_f", o_f, 0);
      check("rst_result", bus.result, 0);
      check("rst_rv", bus.result_valid, 0);
      rst = 1'b0;
      tick();

      // load and single pass, result held through idle cycles
      for (int k = 0; k < LEN; k++) do_write(1'b0, k, W'(k + 1));
      for (int k = 0; k < LEN; k++) do_write(1'b1, k, fv[k]);
      start_pass();
      wait_done();
      check("t1_result", bus.result, 8);
      check("t1_rv", bus.result_valid, 1);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t1_hold_result", bus.result, 8);
         check("t1_hold_rv", bus.result_valid, 1);
         check("t1_idle_busy", bus.busy, 0);
      end

      // write and start while busy are both ignored
      start_pass();
      tick();
      set_write(1'b1, 0, 16'd9, 1'b0);
      bus.start = 1'b1;
      tick();
      bus.wr_en = 1'b0;
      bus.start = 1'b0;
      wait_done();
      repeat (12) tick();
      check("t2_no_second_pass", bus.busy, 0);
      start_pass();
      wait_done();
      tick();

      // write and start in the same idle cycle
      set_write(1'b0, 0, 16'd7, 1'b1);
      start_pass();
      bus.wr_en = 1'b0;
      check("t3_first_operand", o_r, 7);
      wait_done();
      tick();

      // reset in cycle 3 aborts the pass and clears the buffers
      start_pass();
      tick();
      tick();
      rst = 1'b1;
      tick();
      check("t4_o_en", o_en, 0);
      check("t4_busy", bus.busy, 0);
      check("t4_rv", bus.result_valid, 0);
      check("t4_done", bus.done, 0);
      check("t4_result", bus.result, 0);
      exp_op.delete();
      exp_res.delete();
      for (int k = 0; k < LEN; k++) begin
         mdl_r[k] = '0;
         mdl_f[k] = '0;
      end
      rst = 1'b0;
      tick();
      start_pass();
      wait_done();
      tick();

      // back-to-back passes
      for (int k = 0; k < LEN; k++) do_write(1'b0, k, W'(k + 5));
      for (int k = 0; k < LEN; k++) do_write(1'b1, k, W'(4 - k));
      start_pass();
      ca = last_start;
      wait_done();
      tick();
      check("t5_idle_rv", bus.result_valid, 1);
      check("t5_idle_busy", bus.busy, 0);
      start_pass();
      cb = last_start;
      check("t5_rv_dropped", bus.result_valid, 0);
      check("t5_busy", bus.busy, 1);
      check("t5_period", cb - ca, LEN + DRN + 2);
      wait_done();
      repeat (3) tick();
      check("sb_empty", exp_op.size() + exp_res.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pe_row_feeder.md
# pe_row_feeder

Operand sequencer and result collector on the driving side of a four-PE systolic row. Holds one ifmap vector and one filter vector in local register buffers and, on `start`, streams them one element per cycle onto the row's `i_r`/`i_f`/`en` inputs. Appends zero-valued drain cycles and captures the row's `o_psum` into a held result register. Sits between the tile controller and the PE row in the LeViT accelerator datapath.

## Interface

Parameters:
- `WIDTH`, default `definition::width`: operand width; psum width is `2*WIDTH`.
- `LEN`, default 4: elements per vector, equal to the PE count in the row.
- `DRAIN`, default 4: zero-padded cycles after the last operand, covering the row pipeline latency.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  buffer write strobe.
- `wr_sel`  in  1  buffer select: 0 = ifmap, 1 = filter.
- `wr_addr`  in  `$clog2(LEN)`  element index.
- `wr_data`  in  `WIDTH`  element value.
- `start`  in  1  single-cycle request to run one vector pass.
- `busy`  out  1  high while not IDLE.
- `done`  out  1  one-cycle pulse when the result is captured.
- `o_r`  out  `WIDTH`  ifmap operand to the row's `i_r`.
- `o_f`  out  `WIDTH`  filter operand to the row's `i_f`.
- `o_en`  out  1  row enable, drives the row's `en`.
- `i_psum`  in  `2*WIDTH`  row partial sum, from the row's `o_psum`.
- `result`  out  `2*WIDTH`  captured psum.
- `result_valid`  out  1  `result` holds the value from the last completed pass.

## Operation

- FSM states: IDLE → STREAM → DRAIN → DONE → IDLE. An element counter `cnt` runs 0..max(LEN,DRAIN)-1.
- **IDLE:** `o_en`=0, `o_r`/`o_f`=0.
  - Writes are accepted and land on the clock edge.
  - `start` moves to STREAM with `cnt`=0 and clears `result_valid`.
- **STREAM:** `o_en`=1, `o_r`=ifmap[cnt], `o_f`=filter[cnt].
  - At `cnt`=LEN-1, move to DRAIN with `cnt`=0.
- **DRAIN:** `o_en`=1, `o_r`=`o_f`=0.
  - At `cnt`=DRAIN-1, capture `i_psum` into `result` on that edge and move to DONE.
- **DONE:** one cycle. `o_en`=0, `done`=1, `result_valid`=1. Then IDLE.
- `result` and `result_valid` hold until the next accepted `start` or `rst`. Buffers keep their contents across passes.
- Arithmetic: none. Values pass through unmodified; `result` is a straight register copy of `i_psum`, with no truncation or extension.
- Boundary conditions:
  - `wr_en` while `busy`: the write is dropped and buffers are unchanged.
  - `start` while `busy`: ignored.
  - `start` and `wr_en` in the same IDLE cycle: the write commits on that edge, and the pass uses the new value.
  - `wr_addr` ≥ LEN (only possible for non-power-of-2 LEN): the write is dropped.
- Reset (takes priority over everything):
  - State goes to IDLE, `cnt`=0.
  - All outputs go to 0: `busy`, `done`, `o_en`, `o_r`, `o_f`, `result`, `result_valid`.
  - Both buffers are cleared to 0.
  - Asserting `rst` mid-STREAM or mid-DRAIN aborts the pass with no `done`. `o_en` is 0 in the cycle after the reset edge.

## Timing

- Cycle 0 is the edge that samples `start`.
- `o_en` is high for cycles 1..LEN+DRAIN (8 cycles at the defaults).
- Operand k appears on `o_r`/`o_f` in cycle 1+k.
- `i_psum` is sampled at the end of cycle LEN+DRAIN.
- `done` and `result_valid` rise in cycle LEN+DRAIN+1.
- `busy` is high for cycles 1..LEN+DRAIN+1.
- Back-to-back passes: the earliest next `start` is sampled in the first IDLE cycle, giving a period of LEN+DRAIN+2 cycles.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure

- Package `definition`:
  - add `feeder_state_t` (enum IDLE, STREAM, DRAIN, DONE);
  - add constants `ROW_LEN`=4 and `ROW_DRAIN`=4;
  - reuse the existing `width`.
- One natural sub-module, `pe_row_opbuf`: a LEN×WIDTH register buffer with a synchronous write port, combinational read by index, and synchronous clear on `rst`. Instantiate it twice (ifmap, filter).
- The FSM, counter and result register live in `pe_row_feeder`.

## Test plan

- **Load and single pass:** write ifmap {1,2,3,4} and filter {1,2,3,0}, then pulse `start`.
  - `o_r` reads 1,2,3,4,0,0,0,0 and `o_f` reads 1,2,3,0,0,0,0,0 in cycles 1..8.
  - `o_en` is high exactly those 8 cycles.
  - `done` is high in cycle 9.
- **Capture point:** the bench drives `i_psum` equal to the cycle number.
  - `result`=8 and `result_valid`=1 from cycle 9, and both hold through 5 idle cycles.
- **Busy protection:** during STREAM, write filter[0]=9 and pulse `start` again.
  - The stream is unchanged and there is no second pass.
  - A following pass shows filter[0]=1.
- **Same-cycle write and start:** in IDLE, write ifmap[0]=7 together with `start`.
  - `o_r`=7 in cycle 1.
- **Reset mid-pass:** assert `rst` in cycle 3.
  - The next cycle has `o_en`=0, `busy`=0 and `result_valid`=0, with no `done`.
  - Both buffers read 0 on the next pass.
- **Back-to-back passes:** issue `start` in the first IDLE cycle after `done`.
  - The second pass begins LEN+DRAIN+2 cycles after the first.
  - `result_valid` drops on the accepting edge.
